// File: rtl/hdb3n_pkg.sv
// rtl/hdb3n_pkg.sv - shared constants and helpers for the HDBn line decoder
package hdb3n_pkg;

  // Line polarity as carried on the negative rail
  localparam logic POL_POS = 1'b0;
  localparam logic POL_NEG = 1'b1;

  localparam int DEF_ZERO_RUN   = 3;
  localparam int DEF_LOS_THRESH = 32;
  localparam int DEF_ERR_CNT_W  = 16;

  // Zero counter must hold the value LOS_THRESH itself (it saturates there)
  function automatic int zcnt_width(input int los_thresh);
    return $clog2(los_thresh + 1);
  endfunction

endpackage

// File: rtl/hdb3n_los_mon.sv
// rtl/hdb3n_los_mon.sv - loss-of-signal monitor: saturating zero-run counter and LOS flag
module hdb3n_los_mon
  import hdb3n_pkg::*;
#(
  parameter int LOS_THRESH = DEF_LOS_THRESH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  input  logic i_pulse,
  output logic o_los
);

  localparam int CW = zcnt_width(LOS_THRESH);
  localparam logic [CW-1:0] THRESH = CW'(LOS_THRESH);

  logic [CW-1:0] zcnt_q, zcnt_d;
  logic          los_q, los_d;

  // Count accepted zero samples; a pulse clears both the count and LOS
  always_comb begin
    zcnt_d = zcnt_q;
    los_d  = los_q;
    if (i_valid) begin
      if (i_pulse) begin
        zcnt_d = '0;
        los_d  = 1'b0;
      end else if (zcnt_q != THRESH) begin
        zcnt_d = zcnt_q + 1'b1;
        if (zcnt_d == THRESH) los_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      zcnt_q <= '0;
      los_q  <= 1'b0;
    end else begin
      zcnt_q <= zcnt_d;
      los_q  <= los_d;
    end
  end

  assign o_los = los_q;

endmodule

// File: rtl/hdb3n_decode.sv
// rtl/hdb3n_decode.sv - HDBn dual-rail decoder to NRZ; HDB3N_ERR_CNT_EN enables the error counter
module hdb3n_decode
  import hdb3n_pkg::*;
#(
  parameter int ZERO_RUN   = DEF_ZERO_RUN,
  parameter int LOS_THRESH = DEF_LOS_THRESH,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_pos,
  input  logic                 i_neg,
  output logic                 o_data,
  output logic                 o_valid,
  output logic                 o_cv_err,
  output logic                 o_los,
  input  logic                 i_err_clr,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam int PW = $clog2(ZERO_RUN + 1);
  localparam logic [PW-1:0] PRIME_N = PW'(ZERO_RUN);

  // m_q[0] is the previous sample's mark, m_q[ZERO_RUN-1] the oldest
  logic [ZERO_RUN-1:0] m_q, m_d;
  logic [PW-1:0]       pcnt_q;
  logic                have_pulse_q, last_pol_q;
  logic                have_v_q, last_v_pol_q;
  logic                data_q, valid_q, cv_q;

  logic illegal, pulse, pol, viol, between, cv, primed;

  // Classify the incoming sample and detect bipolar violations
  always_comb begin
    illegal = i_pos & i_neg;
    pulse   = i_pos ^ i_neg;
    pol     = i_neg ? POL_NEG : POL_POS;
    viol    = pulse & have_pulse_q & (pol == last_pol_q);
    between = |m_q[ZERO_RUN-2:0];
    cv      = illegal
            | (viol & between)
            | (viol & have_v_q & (pol == last_v_pol_q));
    m_d     = {m_q[ZERO_RUN-2:0], pulse & ~viol};
    primed  = (pcnt_q == PRIME_N);
  end

  // Decode pipeline: a violation blanks the oldest slot (B or leading zero)
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_q          <= '0;
      pcnt_q       <= '0;
      have_pulse_q <= 1'b0;
      last_pol_q   <= POL_POS;
      have_v_q     <= 1'b0;
      last_v_pol_q <= POL_POS;
      data_q       <= 1'b0;
      valid_q      <= 1'b0;
      cv_q         <= 1'b0;
    end else begin
      valid_q <= i_valid & primed;
      cv_q    <= i_valid & cv;
      if (i_valid) begin
        data_q <= viol ? 1'b0 : m_q[ZERO_RUN-1];
        m_q    <= m_d;
        if (pulse) begin
          have_pulse_q <= 1'b1;
          last_pol_q   <= pol;
        end
        if (viol) begin
          have_v_q     <= 1'b1;
          last_v_pol_q <= pol;
        end
        if (!primed) pcnt_q <= pcnt_q + 1'b1;
      end
    end
  end

  hdb3n_los_mon #(
    .LOS_THRESH(LOS_THRESH)
  ) u_los_mon (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .i_pulse(pulse),
    .o_los  (o_los)
  );

  assign o_data   = data_q;
  assign o_valid  = valid_q;
  assign o_cv_err = cv_q;

`ifdef HDB3N_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Saturating count of reported code violations; clear wins over increment
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_cnt_q <= '0;
    end else if (i_err_clr) begin
      err_cnt_q <= '0;
    end else if (cv_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign o_err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_err_cnt      = '0;
`endif

endmodule

// File: tb/tb_hdb3n_decode.sv
// tb/tb_hdb3n_decode.sv - self-checking bench: HDBn encoder model, directed patterns, random streams
module tb_hdb3n_decode;

  localparam int N  = 3;
  localparam int TH = 32;
  localparam int EW = 16;
`ifdef HDB3N_ERR_CNT_EN
  localparam int ERR_AFTER_ILLEGAL = 1;
`else
  localparam int ERR_AFTER_ILLEGAL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          pos = 1'b0;
  logic          neg = 1'b0;
  logic          err_clr = 1'b0;
  logic          data_o, valid_o, cv_o, los_o;
  logic [EW-1:0] err_o;

  always #5 clk = ~clk;

  hdb3n_decode #(
    .ZERO_RUN(N), .LOS_THRESH(TH), .ERR_CNT_W(EW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_pos(pos), .i_neg(neg),
    .o_data(data_o), .o_valid(valid_o), .o_cv_err(cv_o), .o_los(los_o),
    .i_err_clr(err_clr), .o_err_cnt(err_o)
  );

  int total = 0;
  int bad = 0;

  // Behavioural model state: intended bits of accepted samples, zero run, error count
  bit expq[$];
  bit last_data = 1'b0;
  int zrun = 0;
  bit exp_los = 1'b0;
  int exp_err = 0;
  bit prev_cv = 1'b0;
  int emitted_dut = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive a sample with its intended data bit and expected violation flag
  task automatic step(input bit v, input bit p, input bit n, input bit b, input bit cv);
    bit ev;
    bit ed;
    valid = v; pos = p; neg = n;
    ev = 1'b0;
    ed = last_data;
    if (v) begin
      expq.push_back(b);
      if (expq.size() > N) begin
        ev = 1'b1;
        ed = expq.pop_front();
      end
      if (p ^ n) begin
        zrun = 0;
        exp_los = 1'b0;
      end else begin
        zrun++;
        if (zrun >= TH) exp_los = 1'b1;
      end
    end
`ifdef HDB3N_ERR_CNT_EN
    if (err_clr) exp_err = 0;
    else if (prev_cv) exp_err++;
`endif
    prev_cv = v & cv;
    @(posedge clk); #1;
    check("o_valid", valid_o, ev);
    check("o_data", data_o, ed);
    check("o_cv_err", cv_o, v & cv);
    check("o_los", los_o, exp_los);
    check("o_err_cnt", err_o, exp_err);
    if (valid_o) emitted_dut++;
    last_data = ed;
  endtask

  // One-clock reset with an illegal sample presented, so reset must dominate
  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b1; pos = 1'b1; neg = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expq.delete();
    last_data = 1'b0; zrun = 0; exp_los = 1'b0; exp_err = 0; prev_cv = 1'b0;
    check("rst_o_data", data_o, 0);
    check("rst_o_valid", valid_o, 0);
    check("rst_o_cv_err", cv_o, 0);
    check("rst_o_los", los_o, 0);
    check("rst_o_err_cnt", err_o, 0);
  endtask

  task automatic flush();
    for (int k = 0; k < N; k++) step(1, 0, 0, 0, 0);
  endtask

  // Accepted sample preceded by a random number of idle cycles with garbage rails
  task automatic emit(input bit p, input bit n, input bit b);
    while ($urandom_range(0, 3) == 0)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    step(1, p, n, b, 0);
  endtask

  // Random data encoded with the HDBn substitution rules, expected to decode back unchanged
  task automatic run_random(input int len);
    bit d[$];
    bit last_neg;
    bit allz;
    int since_v;
    int i;
    last_neg = 1'b1;
    since_v = 0;
    for (int k = 0; k < len; k++) d.push_back($urandom_range(0, 9) < 3);
    i = 0;
    while (i < len) begin
      allz = (i + N < len);
      if (allz)
        for (int j = 0; j <= N; j++) if (d[i+j]) allz = 1'b0;
      if (allz) begin
        if (since_v % 2 == 0) begin
          last_neg = ~last_neg;
          emit(~last_neg, last_neg, 0);
          for (int j = 0; j < N - 1; j++) emit(0, 0, 0);
        end else begin
          for (int j = 0; j < N; j++) emit(0, 0, 0);
        end
        emit(~last_neg, last_neg, 0);
        since_v = 0;
        i += N + 1;
      end else if (d[i]) begin
        last_neg = ~last_neg;
        emit(~last_neg, last_neg, 1);
        since_v++;
        i++;
      end else begin
        emit(0, 0, 0);
        i++;
      end
    end
    flush();
  endtask

  initial begin
    do_reset();

    // AMI ones: eight marks decode to eight ones
    emitted_dut = 0;
    for (int k = 0; k < 8; k++) step(1, k % 2 == 0, k % 2 == 1, 1, 0);
    flush();
    check("ami_valid_count", emitted_dut, 8);

    // + 0 0 0 V+ -  ->  1 0 0 0 0 1
    do_reset();
    step(1, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    flush();

    // + B- 0 0 V-  ->  1 0 0 0 0
    do_reset();
    step(1, 1, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    flush();

    // Illegal sample decodes as zero and raises a violation
    do_reset();
    step(1, 1, 0, 1, 0);
    step(1, 1, 1, 0, 1);
    flush();
    check("err_cnt_after_illegal", err_o, ERR_AFTER_ILLEGAL);
    err_clr = 1'b1;
    step(1, 0, 1, 1, 0);
    err_clr = 1'b0;
    check("err_cnt_after_clear", err_o, 0);
    flush();

    // Pulse between B and V: + - 0 -  ->  0 1 0 0, violation on the last sample
    do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1);
    flush();

    // Two successive violations of the same polarity: + 0 0 + 0 0 +
    do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    flush();

    // LOS: zero samples interleaved with idle cycles, then a pulse clears it
    do_reset();
    for (int k = 0; k < 31; k++) begin
      step(1, 0, 0, 0, 0);
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    end
    check("los_before_32", los_o, 0);
    step(1, 0, 0, 0, 0);
    check("los_at_32", los_o, 1);
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
    end
    check("los_held", los_o, 1);
    step(1, 1, 0, 1, 0);
    check("los_cleared", los_o, 0);
    flush();

    // Reset mid-pattern: next + must not be taken as a violation of the prior +
    do_reset();
    for (int k = 0; k < 5; k++) step(1, k % 2 == 0, k % 2 == 1, 1, 0);
    do_reset();
    emitted_dut = 0;
    for (int k = 0; k < 4; k++) step(1, k % 2 == 0, k % 2 == 1, 1, 0);
    flush();
    check("post_reset_valid_count", emitted_dut, 4);

    // Randomised HDBn streams with idle gaps, separated by resets
    for (int r = 0; r < 4; r++) begin
      do_reset();
      run_random(300);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
